hazard_detection_unit: RTL and testbench
========================================

// Module: hazard_detection_unit
// PURPOSE
//  Stall/flush controller that complements the operand-forwarding unit: covers the hazards forwarding cannot.
//  Inserts exactly one bubble on a load-use hazard and flushes on a taken branch or jump.
//  Freezes the pipeline while data memory is busy.
//  Drives PC, IF/ID and ID/EX write enables and flush controls; sits beside the ID stage.
// PARAMETERS
//  REG_ADDR_W   5    register-specifier width
//  TIMEOUT_W    8    width of memory-wait cycle counter
//  MEM_TIMEOUT  200  wait cycles after which MemTimeout is raised (must fit TIMEOUT_W)
// PORTS
//  clk               in   1           system clock, rising edge
//  reset             in   1           synchronous, active-high
//  IF_ID_RegisterRS  in   REG_ADDR_W  rs of instruction in ID
//  IF_ID_RegisterRT  in   REG_ADDR_W  rt of instruction in ID
//  ID_UsesRT         in   1           ID instruction reads rt as a source (R-type, store, beq/bne)
//  ID_EX_RegisterRT  in   REG_ADDR_W  destination rt of instruction in EX
//  ID_EX_MemRead     in   1           instruction in EX is a load
//  BranchTaken       in   1           branch in EX resolved taken
//  JMP               in   1           jump decoded in ID
//  MemBusy           in   1           data memory not ready this cycle
//  PCWrite           out  1           PC update enable
//  IF_ID_Write       out  1           IF/ID register enable
//  ID_EX_Bubble      out  1           zero ID/EX control fields (inject NOP)
//  IF_ID_Flush       out  1           clear IF/ID to NOP
//  ID_EX_Flush       out  1           clear ID/EX to NOP
//  PipeHold          out  1           hold ID/EX, EX/MEM and MEM/WB registers
//  MemTimeout        out  1           sticky error: MemBusy held >= MEM_TIMEOUT cycles
//  HazState          out  2           current FSM state (debug)
// BEHAVIOUR
//  Interface: one clock, clk. Reset is synchronous and active-high, port reset.
//  Reset: state=RUN, counter=0, MemTimeout=0.
//   Outputs return to defaults in the same cycle: PCWrite=1, IF_ID_Write=1, all other outputs 0.
//  Output timing: control outputs are combinational from the registered state and current inputs (0-cycle latency).
//   State, counter and MemTimeout update on the rising edge of clk.
//  loaduse = ID_EX_MemRead && ID_EX_RegisterRT!=0 &&
//            (ID_EX_RegisterRT==IF_ID_RegisterRS || (ID_UsesRT && ID_EX_RegisterRT==IF_ID_RegisterRT))
//  States: RUN=0, LDSTALL=1, FLUSH=2, MEMWAIT=3. Priority in RUN: MemBusy > BranchTaken > loaduse > JMP.
//  RUN, MemBusy: PCWrite=0, IF_ID_Write=0, PipeHold=1; counter<=1; next MEMWAIT.
//  RUN, BranchTaken: IF_ID_Flush=1, ID_EX_Flush=1; next FLUSH. A concurrent loaduse is ignored (ID instruction is squashed).
//  RUN, loaduse: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; next LDSTALL.
//  RUN, JMP only: IF_ID_Flush=1; stays RUN.
//  LDSTALL: default outputs; next RUN (or MEMWAIT if MemBusy). Never produces two consecutive bubbles.
//  FLUSH: default outputs; loaduse and JMP suppressed (ID holds a NOP); next RUN (or MEMWAIT if MemBusy).
//  MEMWAIT: freeze outputs as above while MemBusy=1.
//   Counter increments and saturates at 2^TIMEOUT_W-1.
//   counter==MEM_TIMEOUT sets MemTimeout (sticky until reset).
//   When MemBusy=0: default outputs, counter<=0, next RUN. Held BranchTaken/loaduse are re-evaluated in RUN on the following cycle.
//  Reset mid-stall or mid-wait aborts immediately. No bubble or flush is emitted in the reset cycle.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs StallCount[31:0] and FlushCount[31:0], saturating at 2^32-1, cleared by reset.
//   StallCount increments on each ID_EX_Bubble cycle.
//   FlushCount increments on each cycle with IF_ID_Flush=1.
//  Macro undefined: these ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package mips_hazard_pkg: state encodings RUN/LDSTALL/FLUSH/MEMWAIT, REG_ADDR_W default, reset/default output constants.
//  Sub-module sat_counter (WIDTH param, inc, clr, sync reset).
//   Instantiated twice under HAZARD_PERF_CNT_EN; reusable for the MEMWAIT counter.
// TESTING
//  1 lw $2 in EX, add rs=$2 in ID -> one cycle PCWrite=0/IF_ID_Write=0/ID_EX_Bubble=1, then HazState=LDSTALL, then RUN.
//  2 lw $0 in EX, ID reads $0; also sw with ID_UsesRT=0 matching rt -> no stall.
//  3 BranchTaken=1 together with loaduse -> IF_ID_Flush=ID_EX_Flush=1, no bubble; next cycle loaduse=1 ignored (FLUSH).
//  4 MemBusy for 3 cycles -> PipeHold=1 for 3 cycles, PCWrite=0, HazState=3; release -> RUN, MemTimeout=0.
//  5 MEM_TIMEOUT=4, MemBusy held 10 cycles -> MemTimeout rises at the 4th wait cycle and stays 1 after release.
//  6 reset asserted during MEMWAIT -> next edge HazState=0, PCWrite=1, MemTimeout=0; with macro defined, StallCount=0.

Source files
------------

// File: rtl/mips_hazard_pkg.sv
// Shared definitions for the MIPS hazard detection unit: FSM state encodings,
// the bundle of pipeline control outputs and its reset/freeze values.
package mips_hazard_pkg;

    localparam int DEF_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2,
        MEMWAIT = 2'd3
    } hazState_t;

    typedef struct packed {
        logic pcWrite;
        logic ifIdWrite;
        logic idExBubble;
        logic ifIdFlush;
        logic idExFlush;
        logic pipeHold;
    } hazCtrl_t;

    localparam hazState_t RESET_STATE = RUN;

    // Free-running pipeline: only the PC and IF/ID enables are asserted.
    localparam hazCtrl_t CTRL_DEFAULT = '{pcWrite: 1'b1, ifIdWrite: 1'b1, default: 1'b0};

    // Whole pipeline frozen while data memory is busy.
    localparam hazCtrl_t CTRL_FREEZE = '{pipeHold: 1'b1, default: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; synchronous active-high reset
// and synchronous clear.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller beside the ID stage: load-use bubbles, branch/jump flushes
// and memory-busy freezes. Optional HAZARD_PERF_CNT_EN adds StallCount/FlushCount.
module hazard_detection_unit
    import mips_hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRS,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRT,
    input  logic                  ID_UsesRT,
    input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRT,
    input  logic                  ID_EX_MemRead,
    input  logic                  BranchTaken,
    input  logic                  JMP,
    input  logic                  MemBusy,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  ID_EX_Bubble,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Flush,
    output logic                  PipeHold,
    output logic                  MemTimeout,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]           StallCount,
    output logic [31:0]           FlushCount,
`endif
    output logic [1:0]            HazState
);

    hazState_t            state;
    hazState_t            stateNext;
    hazCtrl_t             ctrl;
    logic                 loadUse;
    logic                 waitInc;
    logic                 waitClr;
    logic [TIMEOUT_W-1:0] waitCount;

    assign loadUse = ID_EX_MemRead && (ID_EX_RegisterRT != '0) &&
                     ((ID_EX_RegisterRT == IF_ID_RegisterRS) ||
                      (ID_UsesRT && (ID_EX_RegisterRT == IF_ID_RegisterRT)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESET_STATE;
        end else begin
            state <= stateNext;
        end
    end

    // Reset forces defaults so nothing is bubbled or flushed in the reset cycle.
    // LDSTALL and FLUSH ignore loaduse/JMP: the ID slot already holds a NOP.
    always_comb begin
        ctrl      = CTRL_DEFAULT;
        stateNext = state;
        waitInc   = 1'b0;
        waitClr   = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    if (MemBusy) begin
                        ctrl      = CTRL_FREEZE;
                        waitInc   = 1'b1;
                        stateNext = MEMWAIT;
                    end else if (BranchTaken) begin
                        ctrl.ifIdFlush = 1'b1;
                        ctrl.idExFlush = 1'b1;
                        stateNext      = FLUSH;
                    end else if (loadUse) begin
                        ctrl.pcWrite    = 1'b0;
                        ctrl.ifIdWrite  = 1'b0;
                        ctrl.idExBubble = 1'b1;
                        stateNext       = LDSTALL;
                    end else if (JMP) begin
                        ctrl.ifIdFlush = 1'b1;
                    end
                end
                LDSTALL, FLUSH: begin
                    stateNext = MemBusy ? MEMWAIT : RUN;
                end
                MEMWAIT: begin
                    if (MemBusy) begin
                        ctrl    = CTRL_FREEZE;
                        waitInc = 1'b1;
                    end else begin
                        waitClr   = 1'b1;
                        stateNext = RUN;
                    end
                end
                default: stateNext = RUN;
            endcase
        end
    end

    // Counter is zero in RUN, so the first busy cycle loads it to 1.
    sat_counter #(
        .WIDTH (TIMEOUT_W)
    ) uWaitCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (waitInc),
        .clr   (waitClr),
        .count (waitCount)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            MemTimeout <= 1'b0;
        end else if (waitInc && (waitCount == TIMEOUT_W'(MEM_TIMEOUT - 1))) begin
            MemTimeout <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(
        .WIDTH (32)
    ) uStallCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl.idExBubble),
        .clr   (1'b0),
        .count (StallCount)
    );

    sat_counter #(
        .WIDTH (32)
    ) uFlushCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl.ifIdFlush),
        .clr   (1'b0),
        .count (FlushCount)
    );
`endif

    assign PCWrite      = ctrl.pcWrite;
    assign IF_ID_Write  = ctrl.ifIdWrite;
    assign ID_EX_Bubble = ctrl.idExBubble;
    assign IF_ID_Flush  = ctrl.ifIdFlush;
    assign ID_EX_Flush  = ctrl.idExFlush;
    assign PipeHold     = ctrl.pipeHold;
    assign HazState     = state;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed hazard scenarios followed by
// randomized traffic, all compared against a behavioural model of the hazard rules.
module tb_hazard_detection_unit;

    localparam int RW = 5;
    localparam int TW = 8;
    localparam int MT = 4;
    localparam int WAIT_MAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] idRs;
    logic [RW-1:0] idRt;
    logic          idUsesRt;
    logic [RW-1:0] exRt;
    logic          exMemRead;
    logic          branchTaken;
    logic          jmp;
    logic          memBusy;
    logic          pcWrite;
    logic          ifIdWrite;
    logic          idExBubble;
    logic          ifIdFlush;
    logic          idExFlush;
    logic          pipeHold;
    logic          memTimeout;
    logic [1:0]    hazState;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   stallCount;
    logic [31:0]   flushCount;
`endif

    int checks = 0;
    int errors = 0;

    // Model: 0 running, 1 just bubbled, 2 just flushed, 3 waiting on memory.
    int mPhase;
    int mWait;
    bit mTimeout;
    int mStall;
    int mFlush;

    hazard_detection_unit #(
        .REG_ADDR_W  (RW),
        .TIMEOUT_W   (TW),
        .MEM_TIMEOUT (MT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .IF_ID_RegisterRS (idRs),
        .IF_ID_RegisterRT (idRt),
        .ID_UsesRT        (idUsesRt),
        .ID_EX_RegisterRT (exRt),
        .ID_EX_MemRead    (exMemRead),
        .BranchTaken      (branchTaken),
        .JMP              (jmp),
        .MemBusy          (memBusy),
        .PCWrite          (pcWrite),
        .IF_ID_Write      (ifIdWrite),
        .ID_EX_Bubble     (idExBubble),
        .IF_ID_Flush      (ifIdFlush),
        .ID_EX_Flush      (idExFlush),
        .PipeHold         (pipeHold),
        .MemTimeout       (memTimeout),
`ifdef HAZARD_PERF_CNT_EN
        .StallCount       (stallCount),
        .FlushCount       (flushCount),
`endif
        .HazState         (hazState)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, checks outputs mid-cycle, then advances the model at the edge.
    task automatic applyStimulus(input logic rst, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                 input logic usesRt, input logic [RW-1:0] ldRt, input logic memRead,
                                 input logic br, input logic jp, input logic busy);
        bit         ld;
        logic [5:0] exp;
        int         nPhase;
        int         nWait;
        bit         nTimeout;

        reset       = rst;
        idRs        = rs;
        idRt        = rt;
        idUsesRt    = usesRt;
        exRt        = ldRt;
        exMemRead   = memRead;
        branchTaken = br;
        jmp         = jp;
        memBusy     = busy;

        ld       = memRead && (ldRt != 0) && ((ldRt == rs) || (usesRt && (ldRt == rt)));
        exp      = 6'b110000;
        nPhase   = mPhase;
        nWait    = mWait;
        nTimeout = mTimeout;

        if (rst) begin
            nPhase   = 0;
            nWait    = 0;
            nTimeout = 0;
        end else if (busy && (mPhase == 0 || mPhase == 3)) begin
            exp    = 6'b000001;
            nWait  = (mWait < WAIT_MAX) ? mWait + 1 : WAIT_MAX;
            nPhase = 3;
            if (nWait == MT) nTimeout = 1;
        end else if (mPhase == 3) begin
            nWait  = 0;
            nPhase = 0;
        end else if (mPhase == 0 && br) begin
            exp    = 6'b110110;
            nPhase = 2;
        end else if (mPhase == 0 && ld) begin
            exp    = 6'b001000;
            nPhase = 1;
        end else if (mPhase == 0 && jp) begin
            exp = 6'b110100;
        end else begin
            nPhase = busy ? 3 : 0;
        end

        @(negedge clk);
        checkOutput("PCWrite",      32'(pcWrite),    32'(exp[5]));
        checkOutput("IF_ID_Write",  32'(ifIdWrite),  32'(exp[4]));
        checkOutput("ID_EX_Bubble", 32'(idExBubble), 32'(exp[3]));
        checkOutput("IF_ID_Flush",  32'(ifIdFlush),  32'(exp[2]));
        checkOutput("ID_EX_Flush",  32'(idExFlush),  32'(exp[1]));
        checkOutput("PipeHold",     32'(pipeHold),   32'(exp[0]));
        checkOutput("HazState",     32'(hazState),   32'(mPhase));
        checkOutput("MemTimeout",   32'(memTimeout), 32'(mTimeout));
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("StallCount",   stallCount,      32'(mStall));
        checkOutput("FlushCount",   flushCount,      32'(mFlush));
`endif

        @(posedge clk);
        mPhase   = nPhase;
        mWait    = nWait;
        mTimeout = nTimeout;
        if (rst) begin
            mStall = 0;
            mFlush = 0;
        end else begin
            mStall += int'(exp[3]);
            mFlush += int'(exp[2]);
        end
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; idRs = '0; idRt = '0; idUsesRt = 1'b0; exRt = '0;
        exMemRead = 1'b0; branchTaken = 1'b0; jmp = 1'b0; memBusy = 1'b0;
        @(posedge clk);
        #1;
        mPhase = 0; mWait = 0; mTimeout = 0; mStall = 0; mFlush = 0;

        // Reset cycle with a branch and load-use present: no flush or bubble.
        applyStimulus(1'b1, 5'd2, 5'd3, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);

        // Load-use on rs: one bubble, LDSTALL, then back to RUN.
        applyStimulus(1'b0, 5'd2, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd2, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();

        // Load to $0 and a store-style rt match: no stall.
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd5, 5'd2, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd5, 5'd2, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();

        // Branch together with load-use, then load-use/jump suppressed in FLUSH.
        applyStimulus(1'b0, 5'd2, 5'd3, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd2, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Short memory wait, then release.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        idle();

        // Long memory wait: timeout rises and stays set after release.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        idle();
        applyStimulus(1'b0, 5'd2, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a memory wait.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();

        // Randomized traffic over a small register range so hazards are frequent.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) < 2),
                          RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), RW'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 20),
                          ($urandom_range(0, 99) < 25));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
